// File: rtl/data_mem_responder_if.sv
// Bus between the MEM-stage initiator and the data-memory responder.
// Optional macro: DMEM_RANGE_CHECK_EN adds the err signal.
//   mem_r_en / mem_w_en : read / write request, held until ready=1
//   addr / wdata        : byte address and store data
//   rdata               : registered load data
//   ready               : 0 stalls the pipeline
//   err                 : address fault flag (only with DMEM_RANGE_CHECK_EN)
interface data_mem_responder_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
`ifdef DMEM_RANGE_CHECK_EN
  logic        err;
`endif

  modport master (
    output mem_r_en, mem_w_en, addr, wdata,
`ifdef DMEM_RANGE_CHECK_EN
    input  err,
`endif
    input  rdata, ready
  );

  modport slave (
    input  mem_r_en, mem_w_en, addr, wdata,
`ifdef DMEM_RANGE_CHECK_EN
    output err,
`endif
    output rdata, ready
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: serves MEM-stage load/store requests from a word-organised
// SRAM after a fixed number of wait states, stalling the pipeline via ready.
// Optional macro: DMEM_RANGE_CHECK_EN enables address fault detection and the err output.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : data_mem_responder_if.slave (requests in, rdata/ready/err out)
module data_mem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);
  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam logic [31:0] BaseAddr = 32'(BASE_ADDR);
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic            fault_q;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [DEPTH];

  logic            req;
  logic [31:0]     addr_off;
  logic [IdxW-1:0] idx_in;
  logic            fault_in;
  logic            enter_done;
  logic            c_we;
  logic            c_fault;
  logic [IdxW-1:0] c_idx;
  logic [31:0]     c_wdata;
  logic            mem_we;
  logic            unused_addr_bits;

  assign req      = bus.mem_r_en | bus.mem_w_en;
  assign addr_off = bus.addr - BaseAddr;
  // Index wraps: only the low log2(DEPTH) word-address bits select the entry.
  assign idx_in   = addr_off[IdxW+1:2];
  assign unused_addr_bits = ^{addr_off[31:IdxW+2], addr_off[1:0]};

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [32:0] LimAddr = 33'(BASE_ADDR) + 33'(4 * DEPTH);
  logic err_q;

  assign fault_in = (bus.addr[1:0] != 2'b00) || (bus.addr < BaseAddr) ||
                    ({1'b0, bus.addr} >= LimAddr);
  assign bus.err  = err_q;
`else
  assign fault_in = 1'b0;
`endif

  // With zero wait states the commit happens on the capture edge, so the live
  // inputs are used instead of the (not yet loaded) captured copies.
  always_comb begin
    if (state_q == StIdle) begin
      c_we    = bus.mem_w_en;
      c_idx   = idx_in;
      c_wdata = bus.wdata;
      c_fault = fault_in;
    end else begin
      c_we    = we_q;
      c_idx   = idx_q;
      c_wdata = wdata_q;
      c_fault = fault_q;
    end
  end

  assign enter_done = req && (((state_q == StIdle) && (WAIT_CYCLES == 0)) ||
                              ((state_q == StWait) && (cnt_q == 4'd1)));
  assign mem_we     = rst && enter_done && c_we && !c_fault;

  assign bus.ready = !req || (state_q == StDone);
  assign bus.rdata = rdata_q;

  // SRAM array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[c_idx] <= c_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
`ifdef DMEM_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            we_q    <= bus.mem_w_en;
            idx_q   <= idx_in;
            wdata_q <= bus.wdata;
            fault_q <= fault_in;
            cnt_q   <= WaitInit;
            state_q <= (WAIT_CYCLES == 0) ? StDone : StWait;
          end
        end
        StWait: begin
          // A dropped request aborts the access without any side effect.
          if (!req) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= StDone;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (enter_done && !c_we && !c_fault) begin
        rdata_q <= mem[c_idx];
      end
`ifdef DMEM_RANGE_CHECK_EN
      err_q <= enter_done && c_fault;
`endif
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with 3 wait states, one with 0.
// Expected rdata values come from a small memory model and pass through a scoreboard queue.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if if3 ();
  data_mem_responder_if if0 ();

  data_mem_responder #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(if3)
  );
  data_mem_responder #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] mem3 [int];
  logic [31:0] mem0 [int];
  logic [31:0] rd3 = 32'd0;
  logic [31:0] rd0 = 32'd0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit d0, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d);
    if (d0) begin
      if0.mem_r_en = r; if0.mem_w_en = w; if0.addr = a; if0.wdata = d;
    end else begin
      if3.mem_r_en = r; if3.mem_w_en = w; if3.addr = a; if3.wdata = d;
    end
  endtask

  // One complete access; returns in the middle of the DONE cycle.
  task automatic access(input bit d0, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit keep, input string tag);
    int          idx;
    int          stalls;
    bit          done;
    bit          fault;
    logic [31:0] exp;
    logic [31:0] got;
    @(negedge clk);
    drive(d0, r, w, a, d);
    idx   = int'(((a - 32'd1024) >> 2) & 32'd63);
    fault = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
    fault = (a[1:0] != 2'b00) || (a < 32'd1024) || (a >= 32'd1280);
`endif
    exp = d0 ? rd0 : rd3;
    if (!fault) begin
      if (w) begin
        if (d0) mem0[idx] = d; else mem3[idx] = d;
      end else if (r) begin
        exp = d0 ? mem0[idx] : mem3[idx];
      end
    end
    if (d0) rd0 = exp; else rd3 = exp;
    exp_q.push_back(exp);
    stalls = 0;
    done   = 1'b0;
    for (int i = 0; i < 32 && !done; i++) begin
      #1;
      if ((d0 ? if0.ready : if3.ready) === 1'b1) done = 1'b1;
      else begin
        stalls++;
        @(negedge clk);
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_stalls"}, 32'(stalls), d0 ? 32'd1 : 32'd4);
    got = d0 ? if0.rdata : if3.rdata;
    check({tag, "_rdata"}, got, exp_q.pop_front());
`ifdef DMEM_RANGE_CHECK_EN
    check({tag, "_err"}, 32'(d0 ? if0.err : if3.err), 32'(fault));
`endif
    if (!keep) drive(d0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    #2;
    check("rst_rdata", if3.rdata, 32'd0);
    check("rst_ready", 32'(if3.ready), 32'd1);
`ifdef DMEM_RANGE_CHECK_EN
    check("rst_err", 32'(if3.err), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Prime entries used by later steps.
    access(1'b0, 1'b0, 1'b1, 32'd1040, 32'hDEAD0001, 1'b0, "pre1040");
    access(1'b0, 1'b0, 1'b1, 32'd1024, 32'h0BADF00D, 1'b0, "pre1024");
    access(1'b0, 1'b1, 1'b0, 32'd1040, 32'd0, 1'b0, "rd1040a");

    // Reset in the middle of a write's wait states.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'd1040, 32'h00000BAD);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_rdata", if3.rdata, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("midrst_ready", 32'(if3.ready), 32'd1);
    rd3 = 32'd0;
    rd0 = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    access(1'b0, 1'b1, 1'b0, 32'd1040, 32'd0, 1'b0, "rd1040b");

    // Write then read back with 3 wait states.
    access(1'b0, 1'b0, 1'b1, 32'd1028, 32'h12345678, 1'b0, "wr1028");
    access(1'b0, 1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, "rd1028");

    // Zero wait states.
    access(1'b1, 1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 1'b0, "w0_wr1024");
    access(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, "w0_rd1024");

    // Abort after one wait cycle.
    access(1'b0, 1'b0, 1'b1, 32'd1032, 32'h11112222, 1'b0, "wr1032");
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'd1032, 32'h000000AA);
    @(negedge clk);
    #1;
    check("abort_stall", 32'(if3.ready), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    access(1'b0, 1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, "rd1032");

    // Read and write both requested: write wins, rdata untouched.
    access(1'b0, 1'b1, 1'b1, 32'd1036, 32'h00000055, 1'b0, "rw1036");
    access(1'b0, 1'b1, 1'b0, 32'd1036, 32'd0, 1'b0, "rd1036");

    // Back-to-back with request held across DONE.
    access(1'b0, 1'b0, 1'b1, 32'd1044, 32'h00000077, 1'b1, "b2b_wr1044");
    access(1'b0, 1'b1, 1'b0, 32'd1044, 32'd0, 1'b1, "b2b_rd1044");
    access(1'b0, 1'b0, 1'b1, 32'd1025, 32'h00000099, 1'b0, "b2b_wr1025");
    access(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, "rd1024");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
